// File: rtl/pattern_serial_tx.sv
// Serial pattern transmitter: shifts a latched WIDTH-bit pattern out MSB-first, repeated N times.
// Optional macro SER_GAP_EN inserts one idle cycle (out=0, valid=0) between repetitions.
module pattern_serial_tx #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef SER_GAP_EN
    , GAP
`endif
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;     // latched copy used to reload between repetitions
  logic [WIDTH-1:0] sreg, sreg_d;     // bits still to be sent after the one on out
  logic [BW-1:0]    bit_cnt, bit_d;   // index of the bit currently on out
  logic [CNT_W-1:0] rep_cnt, rep_d;
  logic             out_d, valid_d, busy_d, done_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d = state;
    pat_d   = pat_q;
    sreg_d  = sreg;
    bit_d   = bit_cnt;
    rep_d   = rep_cnt;
    out_d   = out;
    valid_d = valid;
    busy_d  = busy;
    done_d  = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          pat_d   = pattern;
          sreg_d  = {pattern[WIDTH-2:0], 1'b0};
          rep_d   = (repeats == '0) ? CNT_W'(1) : repeats;
          bit_d   = '0;
          out_d   = pattern[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          rep_d = rep_cnt - CNT_W'(1);
          if (rep_cnt == CNT_W'(1)) begin
            state_d = IDLE;
            out_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
`ifdef SER_GAP_EN
            state_d = GAP;
            out_d   = 1'b0;
            valid_d = 1'b0;
`else
            sreg_d  = {pat_q[WIDTH-2:0], 1'b0};
            bit_d   = '0;
            out_d   = pat_q[WIDTH-1];
`endif
          end
        end else begin
          out_d  = sreg[WIDTH-1];
          sreg_d = {sreg[WIDTH-2:0], 1'b0};
          bit_d  = bit_cnt + BW'(1);
        end
      end

`ifdef SER_GAP_EN
      GAP: begin
        state_d = SHIFT;
        sreg_d  = {pat_q[WIDTH-2:0], 1'b0};
        bit_d   = '0;
        out_d   = pat_q[WIDTH-1];
        valid_d = 1'b1;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pat_q   <= '0;
      sreg    <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      out     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      pat_q   <= pat_d;
      sreg    <= sreg_d;
      bit_cnt <= bit_d;
      rep_cnt <= rep_d;
      out     <= out_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_pattern_serial_tx.sv
// Self-checking bench for pattern_serial_tx: a per-cycle vector table plus hand-written
// sequences for repeats, overlap detection, optional gap, and asynchronous reset.
module tb_pattern_serial_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] pattern;
  logic [3:0] repeats;
  logic       out, valid, busy, done;

  int checks = 0;
  int errors = 0;

  pattern_serial_tx #(.WIDTH(4), .CNT_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .repeats (repeats),
    .out     (out),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row = inputs driven before an edge, {out,valid,busy,done} expected after it.
  typedef struct {
    logic       st;
    logic [3:0] pat;
    logic [3:0] rep;
    logic [3:0] exp;
  } vec_t;

  vec_t vec[18];

  initial begin
    // 1101 once; back-to-back 1011 started in the done cycle; repeat 0 with mid-stream changes.
    vec[0]  = '{1'b1, 4'b1101, 4'd1, 4'b1110};
    vec[1]  = '{1'b0, 4'b1101, 4'd1, 4'b1110};
    vec[2]  = '{1'b0, 4'b1101, 4'd1, 4'b0110};
    vec[3]  = '{1'b0, 4'b1101, 4'd1, 4'b1110};
    vec[4]  = '{1'b0, 4'b1101, 4'd1, 4'b0001};
    vec[5]  = '{1'b1, 4'b1011, 4'd1, 4'b1110};
    vec[6]  = '{1'b0, 4'b1011, 4'd1, 4'b0110};
    vec[7]  = '{1'b0, 4'b1011, 4'd1, 4'b1110};
    vec[8]  = '{1'b0, 4'b1011, 4'd1, 4'b1110};
    vec[9]  = '{1'b0, 4'b1011, 4'd1, 4'b0001};
    vec[10] = '{1'b0, 4'b1011, 4'd1, 4'b0000};
    vec[11] = '{1'b1, 4'b1011, 4'd0, 4'b1110};
    vec[12] = '{1'b1, 4'b0000, 4'd3, 4'b0110};
    vec[13] = '{1'b0, 4'b0000, 4'd3, 4'b1110};
    vec[14] = '{1'b1, 4'b0000, 4'd3, 4'b1110};
    vec[15] = '{1'b0, 4'b0000, 4'd3, 4'b0001};
    vec[16] = '{1'b0, 4'b0000, 4'd3, 4'b0000};
    vec[17] = '{1'b0, 4'b0000, 4'd3, 4'b0000};

    rst = 1'b1; start = 1'b0; pattern = '0; repeats = '0;
    #12;
    check("reset_state", {28'd0, out, valid, busy, done}, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      start = vec[i].st; pattern = vec[i].pat; repeats = vec[i].rep;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), {28'd0, out, valid, busy, done}, {28'd0, vec[i].exp});
    end

    // Three back-to-back repeats of 1101; count overlapping 1101 matches in the stream.
    begin
      logic [11:0] bits = '0;
      logic [11:0] hit_pos = '0;
      logic [3:0]  win = '0;
      int          vb = 0;
      int          hits = 0;
      @(negedge clk);
      start = 1'b1; pattern = 4'b1101; repeats = 4'd3;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        pattern = 4'b0000;
        bits = {bits[10:0], out};
        if (valid && busy && !done) vb++;
        win = {win[2:0], out};
        if (i >= 3 && win == 4'b1101) begin
          hits++;
          hit_pos[i] = 1'b1;
        end
      end
      @(posedge clk); #1;
      check("rep3_stream", {20'd0, bits}, {20'd0, 12'b110111011101});
      check("rep3_valid_cycles", vb, 12);
      check("rep3_detect_count", hits, 3);
      check("rep3_detect_pos", {20'd0, hit_pos}, {20'd0, 12'b100010001000});
      check("rep3_done", {28'd0, out, valid, busy, done}, 32'd1);
      @(posedge clk); #1;
      check("rep3_idle", {28'd0, out, valid, busy, done}, 32'd0);
    end

`ifdef SER_GAP_EN
    // Two repeats with one idle gap cycle between them.
    begin
      logic [8:0] o_bits = '0;
      logic [8:0] v_bits = '0;
      int         busy_cycles = 0;
      @(negedge clk);
      start = 1'b1; pattern = 4'b1101; repeats = 4'd2;
      for (int i = 0; i < 9; i++) begin
        @(posedge clk); #1;
        start = 1'b0;
        o_bits = {o_bits[7:0], out};
        v_bits = {v_bits[7:0], valid};
        if (busy) busy_cycles++;
      end
      check("gap_out", {23'd0, o_bits}, {23'd0, 9'b110101101});
      check("gap_valid", {23'd0, v_bits}, {23'd0, 9'b111101111});
      check("gap_busy_cycles", busy_cycles, 9);
      @(posedge clk); #1;
      check("gap_done", {28'd0, out, valid, busy, done}, 32'd1);
    end
`endif

    // Asynchronous reset in the middle of a stream, then silence until a new start.
    begin
      int stray = 0;
      @(negedge clk);
      start = 1'b1; pattern = 4'b1101; repeats = 4'd3;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("pre_reset_active", {28'd0, out, valid, busy, done}, 32'b1110);
      #2 rst = 1'b1;
      #1;
      check("async_reset", {28'd0, out, valid, busy, done}, 32'd0);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk); #1;
        if (out || valid || busy || done) stray++;
      end
      check("post_reset_quiet", stray, 0);
      @(negedge clk);
      start = 1'b1; pattern = 4'b1011; repeats = 4'd1;
      @(posedge clk); #1;
      start = 1'b0;
      check("post_reset_restart", {28'd0, out, valid, busy, done}, 32'b1110);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
